// File: rtl/dcache_axi_bridge_if.sv
// dcache_axi_bridge_if: AXI4 memory bus between the cache bridge (master) and memory (slave).
interface dcache_axi_bridge_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid, wready, wlast;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid, rready, rlast;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arlen, arsize, arburst, input arready,
        input rvalid, rdata, rresp, rlast, output rready
    );
    modport slave (
        input awvalid, awaddr, awlen, awsize, awburst, output awready,
        input wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rdata, rresp, rlast, input rready
    );
endinterface

// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: turns one cache-line refill or writeback into a single AXI4 INCR burst
// through a BEATS x DATA_W line buffer shared by both directions.
module dcache_axi_bridge #(
    parameter int BEATS  = 8,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_req,
    input  logic                     c_rw,
    input  logic [ADDR_W-1:0]        c_addr,
    input  logic                     c_fifo_wen,
    input  logic [DATA_W-1:0]        c_fifo_wdata,
    input  logic [$clog2(BEATS)-1:0] c_rd_idx,
    output logic [DATA_W-1:0]        c_rdata,
    output logic                     c_done,
    output logic                     c_err,
    dcache_axi_bridge_if.master      m
);
    localparam int IW = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS * DATA_W / 8 - 1);
    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);
    localparam logic [IW:0] FULL = (IW + 1)'(BEATS);

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;

    state_t            state, nxt;
    logic [DATA_W-1:0] line [BEATS];
    logic [ADDR_W-1:0] addr;
    logic [IW-1:0]     cnt;
    logic [IW:0]       wptr;
    logic              push, rbeat, wbeat, bbeat;

    assign push  = state == IDLE && c_fifo_wen && wptr != FULL;
    assign rbeat = state == R && m.rvalid;
    assign wbeat = state == W && m.wready;
    assign bbeat = state == B && m.bvalid;

    assign c_rdata   = line[c_rd_idx];
    assign m.arvalid = state == AR;
    assign m.rready  = state == R;
    assign m.awvalid = state == AW;
    assign m.wvalid  = state == W;
    assign m.bready  = state == B;
    assign m.araddr  = addr;
    assign m.awaddr  = addr;
    assign m.arlen   = 8'(BEATS - 1);
    assign m.awlen   = 8'(BEATS - 1);
    assign m.arsize  = 3'($clog2(DATA_W / 8));
    assign m.awsize  = 3'($clog2(DATA_W / 8));
    assign m.arburst = 2'b01;
    assign m.awburst = 2'b01;
    assign m.wdata   = line[cnt];
    assign m.wstrb   = '1;
    assign m.wlast   = state == W && cnt == LAST;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = c_req ? (c_rw ? AW : AR) : IDLE;
            AR:      nxt = m.arready ? R : AR;
            R:       nxt = rbeat && (m.rlast || cnt == LAST) ? DONE : R;
            AW:      nxt = m.awready ? W : AW;
            W:       nxt = wbeat && cnt == LAST ? B : W;
            B:       nxt = m.bvalid ? DONE : B;
            DONE:    nxt = c_req ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= '0;
            cnt    <= '0;
            wptr   <= '0;
            c_done <= 1'b0;
            c_err  <= 1'b0;
        end else begin
            state  <= nxt;
            c_done <= state == DONE && c_req;
            if (state == IDLE && c_req) begin
                addr <= c_addr & LINE_MASK;
                cnt  <= '0;
            end
            if (rbeat || wbeat)
                cnt <= cnt + 1'b1;
            if (push)
                wptr <= wptr + 1'b1;
            if (bbeat)
                wptr <= '0;
            if ((rbeat && m.rresp != 2'b00) || (bbeat && m.bresp != 2'b00))
                c_err <= 1'b1;
        end
    end

    // The line buffer is never reset; refill beats and writeback pushes occupy disjoint states.
    always_ff @(posedge clk) begin
        if (push)
            line[wptr[IW-1:0]] <= c_fifo_wdata;
        if (rbeat)
            line[cnt] <= m.rdata;
    end
endmodule

// File: tb/tb_dcache_axi_bridge.sv
// tb_dcache_axi_bridge: directed and randomized refill/writeback traffic against a
// line-buffer model and a procedural AXI slave.
module tb_dcache_axi_bridge;
    localparam int BEATS = 8;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam logic [63:0] LMASK = ~64'(BEATS * DATA_W / 8 - 1);

    logic        clk = 1'b0;
    logic        rst, c_req, c_rw, c_fifo_wen, c_done, c_err;
    logic [63:0] c_addr, c_fifo_wdata, c_rdata;
    logic [2:0]  c_rd_idx;

    logic [63:0] exp_buf [BEATS];
    int          wp;
    bit          exp_err;
    int          total = 0;
    int          bad = 0;

    always #10 clk = ~clk;

    dcache_axi_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dcache_axi_bridge #(.BEATS(BEATS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .c_req(c_req), .c_rw(c_rw), .c_addr(c_addr),
        .c_fifo_wen(c_fifo_wen), .c_fifo_wdata(c_fifo_wdata), .c_rd_idx(c_rd_idx),
        .c_rdata(c_rdata), .c_done(c_done), .c_err(c_err), .m(bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d);
        c_fifo_wen = 1'b1;
        c_fifo_wdata = d;
        tick;
        c_fifo_wen = 1'b0;
        if (wp < BEATS) begin
            exp_buf[wp] = d;
            wp++;
        end
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < BEATS; i++) begin
            c_rd_idx = 3'(i);
            #1;
            chk({tag, "_rdata"}, c_rdata, exp_buf[i]);
        end
    endtask

    task automatic finish_req(input int hold, input string tag);
        bit stay_bad = 0;
        for (int h = 0; h < hold; h++) begin
            tick;
            if (c_done !== 1'b1 || bus.arvalid !== 1'b0 || bus.awvalid !== 1'b0) stay_bad = 1;
        end
        chk({tag, "_hold"}, stay_bad, 0);
        c_req = 1'b0;
        tick;
        chk({tag, "_release"}, c_done, 0);
    endtask

    task automatic refill(input logic [63:0] a, input int ar_wait, input int gap, input int nb,
                          input int err_beat, input bit fixed, input int exp_lat, input int hold,
                          input int abort_at);
        logic [63:0] d [BEATS];
        int cyc = 0, beats = 0, arw = 0, ars = 0;
        bit adr_bad = 0, rv;
        for (int i = 0; i < BEATS; i++) d[i] = fixed ? 64'((i + 1) * 'h11) : {$urandom, $urandom};
        c_rw = 1'b0;
        c_addr = a;
        c_req = 1'b1;
        while (!c_done && cyc < 300) begin
            if (abort_at >= 0 && beats == abort_at && bus.rready) begin
                bus.rvalid = 1'b0;
                c_req = 1'b0;
                rst = 1'b1;
                tick;
                rst = 1'b0;
                chk("rst_rready", bus.rready, 0);
                chk("rst_arvalid", bus.arvalid, 0);
                chk("rst_done", c_done, 0);
                chk("rst_err", c_err, 0);
                exp_err = 0;
                wp = 0;
                tick;
                chk("rst_idle", bus.arvalid, 0);
                return;
            end
            bus.arready = bus.arvalid && arw >= ar_wait;
            if (bus.arvalid) begin
                arw++;
                if (bus.araddr !== (a & LMASK)) adr_bad = 1;
                if (bus.arready) ars++;
            end
            rv = bus.rready && beats < nb &&
                 (gap == 0 || (gap == 1 ? cyc % 2 == 1 : $urandom_range(1) == 1));
            bus.rvalid = rv;
            bus.rdata = rv ? d[beats] : '0;
            bus.rresp = rv && beats == err_beat ? 2'd2 : 2'd0;
            bus.rlast = rv && beats == nb - 1;
            tick;
            cyc++;
            if (rv) begin
                exp_buf[beats] = d[beats];
                if (beats == err_beat) exp_err = 1;
                beats++;
            end
        end
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rlast = 1'b0;
        bus.rresp = 2'd0;
        chk("refill_done", c_done, 1);
        chk("refill_beats", beats, nb);
        chk("refill_ar_count", ars, 1);
        chk("refill_araddr_stable", adr_bad, 0);
        if (exp_lat >= 0) chk("refill_latency", cyc, exp_lat);
        chk("refill_err", c_err, exp_err);
        check_buf("refill");
        finish_req(hold, "refill");
    endtask

    task automatic writeback(input logic [63:0] a, input int mw, input bit berr, input int hold);
        int cyc = 0, k = 0, ahs = 0;
        int aww = $urandom_range(mw);
        int bw = $urandom_range(mw);
        bit aw_done = 0, b_done = 0, seen_w = 0, hsaw, hsw, hsb;
        bit order_bad = 0, data_bad = 0, last_bad = 0, drop_bad = 0, bready_bad = 0, adr_bad = 0;
        c_rw = 1'b1;
        c_addr = a;
        c_req = 1'b1;
        while (!c_done && cyc < 300) begin
            bus.awready = bus.awvalid && aww == 0;
            if (bus.awvalid && aww > 0) aww--;
            if (bus.awvalid && bus.awaddr !== (a & LMASK)) adr_bad = 1;
            if (bus.wvalid && !aw_done) order_bad = 1;
            if (seen_w && k < BEATS && !bus.wvalid) drop_bad = 1;
            if (bus.bready && k < BEATS) bready_bad = 1;
            bus.wready = $urandom_range(mw) == 0;
            hsw = bus.wvalid && bus.wready;
            if (bus.wvalid) begin
                seen_w = 1;
                if (bus.wlast !== (k == BEATS - 1)) last_bad = 1;
                if (hsw && (k >= BEATS || bus.wdata !== exp_buf[k])) data_bad = 1;
            end
            bus.bvalid = bus.bready && bw == 0;
            bus.bresp = berr ? 2'd2 : 2'd0;
            hsaw = bus.awvalid && bus.awready;
            hsb = bus.bready && bus.bvalid;
            if (bus.bready && bw > 0) bw--;
            tick;
            cyc++;
            if (hsaw) begin
                aw_done = 1;
                ahs++;
            end
            if (hsw) k++;
            if (hsb) begin
                b_done = 1;
                wp = 0;
                if (berr) exp_err = 1;
            end
        end
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        bus.bvalid = 1'b0;
        bus.bresp = 2'd0;
        chk("wb_done", c_done, 1);
        chk("wb_beats", k, BEATS);
        chk("wb_aw_count", ahs, 1);
        chk("wb_b_seen", b_done, 1);
        chk("wb_awaddr_stable", adr_bad, 0);
        chk("wb_aw_before_w", order_bad, 0);
        chk("wb_wdata", data_bad, 0);
        chk("wb_wlast", last_bad, 0);
        chk("wb_wvalid_steady", drop_bad, 0);
        chk("wb_bready_after_wlast", bready_bad, 0);
        chk("wb_err", c_err, exp_err);
        check_buf("wb");
        finish_req(hold, "wb");
    endtask

    initial begin
        rst = 1'b1;
        c_req = 1'b0;
        c_rw = 1'b0;
        c_addr = '0;
        c_fifo_wen = 1'b0;
        c_fifo_wdata = '0;
        c_rd_idx = '0;
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        bus.bvalid = 1'b0;
        bus.bresp = 2'd0;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        bus.rresp = 2'd0;
        bus.rlast = 1'b0;
        wp = 0;
        exp_err = 0;
        tick;
        tick;
        chk("reset_arvalid", bus.arvalid, 0);
        chk("reset_awvalid", bus.awvalid, 0);
        chk("reset_wvalid", bus.wvalid, 0);
        chk("reset_rready", bus.rready, 0);
        chk("reset_bready", bus.bready, 0);
        chk("reset_done", c_done, 0);
        chk("reset_err", c_err, 0);
        chk("reset_araddr", bus.araddr, 0);
        chk("reset_awaddr", bus.awaddr, 0);
        chk("arlen", bus.arlen, BEATS - 1);
        chk("awlen", bus.awlen, BEATS - 1);
        chk("arsize", bus.arsize, 3);
        chk("awsize", bus.awsize, 3);
        chk("arburst", bus.arburst, 1);
        chk("awburst", bus.awburst, 1);
        chk("wstrb", bus.wstrb, 8'hFF);
        rst = 1'b0;

        refill(64'h8000_1234, 0, 0, BEATS, 99, 1, 11, 0, -1);
        chk("araddr_aligned", bus.araddr, 64'h8000_1200);
        refill(64'h1234_5678, 4, 1, BEATS, 99, 0, -1, 3, -1);
        refill(64'h0000_4047, 0, 0, BEATS, 99, 0, 11, 0, -1);

        for (int i = 0; i < 9; i++) push(64'hA0 + 64'(i));
        writeback(64'h9000_00BF, 0, 1'b0, 1);
        chk("wb_awaddr_aligned", bus.awaddr, 64'h9000_0080);

        refill(64'h2000_0000, 1, 2, BEATS, 3, 0, -1, 0, -1);
        chk("err_set", c_err, 1);
        for (int i = 0; i < 5; i++) push({$urandom, $urandom});
        writeback(64'h3000_0100, 2, 1'b0, 0);
        chk("err_sticky", c_err, 1);

        refill(64'h4000_0000, 0, 0, BEATS, 99, 0, -1, 0, 3);
        refill(64'h5000_0040, 0, 0, BEATS, 99, 0, 11, 0, -1);

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(1) == 0) begin
                refill({$urandom, $urandom}, $urandom_range(3), 2, $urandom_range(1, BEATS),
                       $urandom_range(11), 0, -1, $urandom_range(2), -1);
            end else begin
                int n = $urandom_range(9);
                for (int i = 0; i < n; i++) push({$urandom, $urandom});
                writeback({$urandom, $urandom}, 2, $urandom_range(3) == 0, $urandom_range(2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
